// File: rtl/watchdog_pkg.sv
// Shared definitions for the result-stream link between output_loader (transmit
// side) and result_receiver (receive side).
//
// Frame layout (11 bytes, words big-endian):
//   SYNC, HDR, A3, A2, A1, A0, B3, B2, B1, B0, CHK
//   HDR[7:5] = marker, HDR[4:3] = reserved, HDR[2:0] = regime
//   CHK      = XOR of HDR and the eight data bytes (SYNC excluded)
package watchdog_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StWordA,
    StWordB,
    StChk
  } rx_state_e;

  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam logic [2:0]  HDR_MARKER  = 3'b010;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned FRAME_LEN   = 11;

  // Counter width able to hold 0 .. TIMEOUT_CYC.
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

endpackage

// File: rtl/result_receiver.sv
// Result-stream receiver: hunts for SYNC_BYTE, checks the header marker,
// collects two 32-bit words into a 64-bit shift register while keeping a
// running XOR, and on a matching checksum publishes kappa / inv_kappa /
// regime together with a one-cycle res_valid pulse. Any framing problem
// (bad marker, bad checksum, inter-byte timeout) yields a one-cycle
// frame_err pulse and leaves the published results untouched.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ena        design enable; low freezes all state and ignores rx_valid
//   rx_byte    incoming stream byte
//   rx_valid   rx_byte is accepted on each enabled edge with rx_valid high
//   kappa      last good word A (signed)
//   inv_kappa  last good word B (signed)
//   regime     last good regime field
//   res_valid  one-cycle pulse: new results latched
//   frame_err  one-cycle pulse: frame discarded
//   busy       high whenever a frame is in progress
module result_receiver
  import watchdog_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [7:0]         rx_byte,
  input  logic               rx_valid,
  output logic signed [31:0] kappa,
  output logic signed [31:0] inv_kappa,
  output logic [2:0]         regime,
  output logic               res_valid,
  output logic               frame_err,
  output logic               busy
);

  rx_state_e         state_q;
  logic [1:0]        byte_cnt_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic [63:0]       shift_q;
  logic [7:0]        xor_q;
  logic [2:0]        regime_tmp_q;
  logic [31:0]       kappa_q;
  logic [31:0]       inv_kappa_q;
  logic [2:0]        regime_q;
  logic              res_valid_q;
  logic              frame_err_q;

  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TIMEOUT_CYC - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      byte_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      shift_q      <= '0;
      xor_q        <= '0;
      regime_tmp_q <= '0;
      kappa_q      <= '0;
      inv_kappa_q  <= '0;
      regime_q     <= '0;
      res_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      // Pulses last exactly one cycle and stay low while disabled.
      res_valid_q <= 1'b0;
      frame_err_q <= 1'b0;

      if (ena) begin
        if (rx_valid) begin
          tmo_cnt_q <= '0;
          unique case (state_q)
            StIdle: begin
              if (rx_byte == SYNC_BYTE) begin
                state_q <= StHdr;
              end
            end
            StHdr: begin
              if (rx_byte[7:5] == HDR_MARKER) begin
                state_q      <= StWordA;
                regime_tmp_q <= rx_byte[2:0];
                xor_q        <= rx_byte;
                byte_cnt_q   <= '0;
              end else begin
                state_q     <= StIdle;
                frame_err_q <= 1'b1;
              end
            end
            StWordA, StWordB: begin
              // SYNC_BYTE values are plain data here.
              shift_q    <= {shift_q[55:0], rx_byte};
              xor_q      <= xor_q ^ rx_byte;
              byte_cnt_q <= byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd3) begin
                state_q <= (state_q == StWordA) ? StWordB : StChk;
              end
            end
            StChk: begin
              state_q <= StIdle;
              if (rx_byte == xor_q) begin
                kappa_q     <= shift_q[63:32];
                inv_kappa_q <= shift_q[31:0];
                regime_q    <= regime_tmp_q;
                res_valid_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end
            default: state_q <= StIdle;
          endcase
        end else if (state_q != StIdle) begin
          // Inter-byte gap inside a frame; abort once it reaches TIMEOUT_CYC.
          if (tmo_cnt_q == TmoLast) begin
            state_q     <= StIdle;
            tmo_cnt_q   <= '0;
            frame_err_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign kappa     = kappa_q;
  assign inv_kappa = inv_kappa_q;
  assign regime    = regime_q;
  assign res_valid = res_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_result_receiver.sv
// Self-checking bench for result_receiver. Frames are assembled at byte level
// from the framing rules; the expected results are tracked per frame.
module tb_result_receiver;

  localparam logic [7:0] SYNC   = 8'hA5;
  localparam logic [2:0] MARKER = 3'b010;
  localparam int         TMO    = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic signed [31:0] kappa;
  logic signed [31:0] inv_kappa;
  logic [2:0]  regime;
  logic        res_valid;
  logic        frame_err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  frm [11];
  logic [31:0] exp_kappa;
  logic [31:0] exp_inv;
  logic [2:0]  exp_regime;

  result_receiver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .kappa     (kappa),
    .inv_kappa (inv_kappa),
    .regime    (regime),
    .res_valid (res_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want normal end");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
  endtask

  task automatic send_range(input int from, input int to);
    for (int i = from; i <= to; i++) send_byte(frm[i]);
  endtask

  // Checksum is the XOR of header and data bytes.
  task automatic build_frame(input logic [7:0] hdr, input logic [31:0] a, input logic [31:0] b);
    logic [7:0] chk;
    frm[0] = SYNC;
    frm[1] = hdr;
    for (int i = 0; i < 4; i++) begin
      frm[2 + i] = a[31 - 8 * i -: 8];
      frm[6 + i] = b[31 - 8 * i -: 8];
    end
    chk = hdr;
    for (int i = 2; i < 10; i++) chk = chk ^ frm[i];
    frm[10] = chk;
  endtask

  task automatic check_results(input string name);
    n_checks++;
    if (kappa !== exp_kappa) $display("FAIL %s kappa: got %h want %h", name, kappa, exp_kappa);
    else n_pass++;
    n_checks++;
    if (inv_kappa !== exp_inv) $display("FAIL %s inv_kappa: got %h want %h", name, inv_kappa, exp_inv);
    else n_pass++;
    n_checks++;
    if (regime !== exp_regime) $display("FAIL %s regime: got %0d want %0d", name, regime, exp_regime);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; ena = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    #2 rst_n = 1'b0;
    #2;
    exp_kappa = '0; exp_inv = '0; exp_regime = '0;
    check_results("reset");
    n_checks++;
    if ({res_valid, frame_err, busy} !== 3'b000)
      $display("FAIL reset pulses/busy: got %b want 000", {res_valid, frame_err, busy});
    else n_pass++;
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_good_frame();
    build_frame(8'h42, 32'h0001_0000, 32'hFFFF_0000);
    send_range(0, 9);
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL good early res_valid: got %b want 0", res_valid);
    else n_pass++;
    send_byte(frm[10]);
    n_checks++;
    if ({res_valid, frame_err} !== 2'b10)
      $display("FAIL good pulses: got %b want 10", {res_valid, frame_err});
    else n_pass++;
    exp_kappa = 32'h0001_0000; exp_inv = 32'hFFFF_0000; exp_regime = 3'd2;
    check_results("good");
    tick();
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL good pulse width: got %b want 0", res_valid);
    else n_pass++;
  endtask

  task automatic test_bad_chk();
    build_frame(8'h42, 32'h0001_0000, 32'hFFFF_0000);
    frm[10] = 8'h00;
    send_range(0, 10);
    n_checks++;
    if ({res_valid, frame_err} !== 2'b01)
      $display("FAIL badchk pulses: got %b want 01", {res_valid, frame_err});
    else n_pass++;
    check_results("badchk");
    tick();
    n_checks++;
    if (frame_err !== 1'b0) $display("FAIL badchk pulse width: got %b want 0", frame_err);
    else n_pass++;
  endtask

  task automatic test_framing();
    send_byte(8'h00);
    send_byte(8'hA4);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL framing noise busy: got %b want 0", busy);
    else n_pass++;
    send_byte(8'hA5);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL framing sync busy: got %b want 1", busy);
    else n_pass++;
    send_byte(8'h1F);
    n_checks++;
    if ({frame_err, busy} !== 2'b10)
      $display("FAIL framing bad hdr: got %b want 10", {frame_err, busy});
    else n_pass++;
    build_frame(8'h47, 32'hDEAD_BEEF, 32'h8000_0001);
    send_range(0, 10);
    n_checks++;
    if (res_valid !== 1'b1) $display("FAIL framing recover res_valid: got %b want 1", res_valid);
    else n_pass++;
    exp_kappa = 32'hDEAD_BEEF; exp_inv = 32'h8000_0001; exp_regime = 3'd7;
    check_results("framing");
  endtask

  task automatic test_timeout();
    build_frame(8'h43, 32'h1111_2222, 32'h3333_4444);
    send_range(0, 4);
    for (int i = 0; i < TMO - 1; i++) tick();
    n_checks++;
    if ({frame_err, busy} !== 2'b01)
      $display("FAIL timeout early: got %b want 01", {frame_err, busy});
    else n_pass++;
    tick();
    n_checks++;
    if ({frame_err, busy} !== 2'b10)
      $display("FAIL timeout fire: got %b want 10", {frame_err, busy});
    else n_pass++;
    tick();
    n_checks++;
    if (frame_err !== 1'b0) $display("FAIL timeout pulse width: got %b want 0", frame_err);
    else n_pass++;
    check_results("timeout");
  endtask

  task automatic test_ena_gating();
    int bad = 0;
    build_frame(8'h45, 32'($urandom), 32'($urandom));
    send_range(0, 5);
    for (int i = 0; i < 5; i++) tick();
    ena = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rx_valid = 1'b1;
      rx_byte  = 8'($urandom);
      tick();
      if (res_valid || frame_err || !busy) bad++;
    end
    rx_valid = 1'b0;
    ena = 1'b1;
    n_checks++;
    if (bad !== 0) $display("FAIL ena frozen: got %0d bad cycles want 0", bad);
    else n_pass++;
    for (int i = 0; i < 5; i++) tick();
    send_range(6, 10);
    n_checks++;
    if (res_valid !== 1'b1) $display("FAIL ena res_valid: got %b want 1", res_valid);
    else n_pass++;
    exp_kappa  = {frm[2], frm[3], frm[4], frm[5]};
    exp_inv    = {frm[6], frm[7], frm[8], frm[9]};
    exp_regime = 3'd5;
    check_results("ena");
  endtask

  task automatic test_reset_mid_frame();
    int errs = 0;
    build_frame(8'h41, 32'h0BAD_F00D, 32'h1234_5678);
    send_range(0, 5);
    #2 rst_n = 1'b0;
    #1;
    exp_kappa = '0; exp_inv = '0; exp_regime = '0;
    check_results("midreset");
    n_checks++;
    if ({res_valid, frame_err, busy} !== 3'b000)
      $display("FAIL midreset pulses/busy: got %b want 000", {res_valid, frame_err, busy});
    else n_pass++;
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (frame_err || busy) errs++;
    end
    n_checks++;
    if (errs !== 0) $display("FAIL midreset after: got %0d err cycles want 0", errs);
    else n_pass++;
    send_range(0, 10);
    n_checks++;
    if (res_valid !== 1'b1) $display("FAIL midreset new frame: got %b want 1", res_valid);
    else n_pass++;
    exp_kappa = 32'h0BAD_F00D; exp_inv = 32'h1234_5678; exp_regime = 3'd1;
    check_results("midreset frame");
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      build_frame({MARKER, 2'($urandom), 3'($urandom)}, 32'($urandom), 32'($urandom));
      send_range(0, 10);
      n_checks++;
      if ({res_valid, frame_err} !== 2'b10)
        $display("FAIL b2b pulses: got %b want 10", {res_valid, frame_err});
      else n_pass++;
      exp_kappa  = {frm[2], frm[3], frm[4], frm[5]};
      exp_inv    = {frm[6], frm[7], frm[8], frm[9]};
      exp_regime = frm[1][2:0];
      check_results("b2b");
    end
  endtask

  // One optional pause before a byte: either an enabled idle cycle or a
  // disabled cycle with junk on the bus, which must be ignored.
  task automatic maybe_gap();
    if ($urandom_range(0, 3) == 0) begin
      if ($urandom_range(0, 1) == 1) begin
        ena = 1'b0; rx_valid = 1'b1; rx_byte = 8'($urandom);
        tick();
        ena = 1'b1; rx_valid = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_random();
    int kind;
    int last;
    logic [7:0] noise;
    logic [2:0] mk;
    for (int f = 0; f < 40; f++) begin
      for (int n = $urandom_range(0, 3); n > 0; n--) begin
        noise = 8'($urandom);
        if (noise == SYNC) noise = 8'h5A;
        send_byte(noise);
      end
      kind = $urandom_range(0, 9);
      mk = MARKER;
      if (kind >= 8) begin
        mk = 3'($urandom);
        if (mk == MARKER) mk = 3'b111;
      end
      build_frame({mk, 2'($urandom), 3'($urandom)}, 32'($urandom), 32'($urandom));
      if (kind == 6 || kind == 7) frm[10] = frm[10] ^ 8'($urandom_range(1, 255));
      last = (kind >= 8) ? 1 : 10;
      for (int i = 0; i <= last; i++) begin
        if (i > 0) maybe_gap();
        send_byte(frm[i]);
      end
      if (kind < 6) begin
        exp_kappa  = {frm[2], frm[3], frm[4], frm[5]};
        exp_inv    = {frm[6], frm[7], frm[8], frm[9]};
        exp_regime = frm[1][2:0];
      end
      n_checks++;
      if ({res_valid, frame_err} !== ((kind < 6) ? 2'b10 : 2'b01))
        $display("FAIL random frame %0d kind %0d pulses: got %b want %b", f, kind,
                 {res_valid, frame_err}, (kind < 6) ? 2'b10 : 2'b01);
      else n_pass++;
      check_results("random");
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_framing();
    test_timeout();
    test_ena_gating();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
